// File: rtl/instr_mem_loader.sv
// instr_mem_loader: packs decoded instruction fields into the 49-bit
// instruction word and writes the words sequentially into instruction memory
// from a programmed base address. Reports busy, done, word count and a
// sticky overflow flag when the address space runs out.
module instr_mem_loader #(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [4:0]        in_op,
  input  logic [1:0]        in_mode,
  input  logic [4:0]        in_src,
  input  logic [4:0]        in_dst,
  input  logic [31:0]       in_lit,
  input  logic              in_last,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [48:0]       imem_wdata,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W:0]   count,
  output logic              err
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t              state;
  logic [ADDR_W-1:0]   wr_ptr;
  logic                wrapped;
  logic                beat_acc;

  // Canonical instruction layout: op | mode | src | dst | literal.
  function automatic logic [48:0] encode_word(
    input logic [4:0]  op,
    input logic [1:0]  mode,
    input logic [4:0]  src,
    input logic [4:0]  dst,
    input logic [31:0] lit
  );
    return {op, mode, src, dst, lit};
  endfunction

  assign in_ready = (state == LOAD);
  assign busy     = (state != IDLE);
  assign done     = (state == DONE);
  assign beat_acc = in_valid && (state == LOAD);

  // Session FSM plus the registered memory write port. Once the pointer has
  // passed the top of memory, further beats are consumed but dropped so the
  // upstream source never stalls and in_last still closes the session.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      wr_ptr     <= '0;
      wrapped    <= 1'b0;
      count      <= '0;
      err        <= 1'b0;
      imem_we    <= 1'b0;
      imem_addr  <= '0;
      imem_wdata <= '0;
    end else begin
      imem_we <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state   <= LOAD;
            wr_ptr  <= base_addr;
            count   <= '0;
            err     <= 1'b0;
            wrapped <= 1'b0;
          end
        end
        LOAD: begin
          if (beat_acc) begin
            if (!wrapped) begin
              imem_we    <= 1'b1;
              imem_addr  <= wr_ptr;
              imem_wdata <= encode_word(in_op, in_mode, in_src, in_dst, in_lit);
              wr_ptr     <= wr_ptr + 1'b1;
              count      <= count + 1'b1;
              if (wr_ptr == LAST_ADDR) begin
                wrapped <= 1'b1;
              end
            end else begin
              err <= 1'b1;
            end
            if (in_last) begin
              state <= DONE;
            end
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_instr_mem_loader.sv
// Randomized scoreboard bench for instr_mem_loader. The driver predicts the
// write stream of each session from the address range arithmetic and pushes
// it into a queue; a negedge monitor pops and compares every memory write.
module tb_instr_mem_loader;

  localparam int ADDR_W = 8;
  localparam int DEPTH  = 1 << ADDR_W;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic [ADDR_W-1:0] base_addr;
  logic              in_valid;
  logic              in_ready;
  logic [4:0]        in_op;
  logic [1:0]        in_mode;
  logic [4:0]        in_src;
  logic [4:0]        in_dst;
  logic [31:0]       in_lit;
  logic              in_last;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [48:0]       imem_wdata;
  logic              busy;
  logic              done;
  logic [ADDR_W:0]   count;
  logic              err;

  int errors = 0;
  int checks = 0;
  int done_seen = 0;
  int done_exp = 0;

  logic [ADDR_W+48:0] exp_q[$];

  instr_mem_loader #(.ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
    .in_mode(in_mode), .in_src(in_src), .in_dst(in_dst), .in_lit(in_lit),
    .in_last(in_last), .imem_we(imem_we), .imem_addr(imem_addr),
    .imem_wdata(imem_wdata), .busy(busy), .done(done), .count(count),
    .err(err)
  );

  always #5 clk = ~clk;

  // Monitor: every write must match the oldest predicted write.
  always @(negedge clk) begin
    if (imem_we) begin
      logic [ADDR_W+48:0] e;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_write addr=%h wdata=%h (no write expected)", imem_addr, imem_wdata);
      end else begin
        e = exp_q.pop_front();
        if ({imem_addr, imem_wdata} !== e) begin
          errors++;
          $display("FAIL write addr=%h wdata=%h expected addr=%h wdata=%h",
                   imem_addr, imem_wdata, e[ADDR_W+48:49], e[48:0]);
        end
      end
    end
    if (done) done_seen++;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h", name, act, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rand_fields();
    in_op   = 5'($urandom_range(0, 31));
    in_mode = 2'($urandom_range(0, 3));
    in_src  = 5'($urandom_range(0, 31));
    in_dst  = 5'($urandom_range(0, 31));
    in_lit  = $urandom();
  endtask

  // One complete session: start, n beats with random gaps, then DONE/IDLE checks.
  task automatic session(input int base, input int n, input int maxgap,
                         input bit spurious_start, input bit directed);
    int room;
    int exp_cnt;
    bit exp_err;
    logic [48:0] w;
    logic [ADDR_W-1:0] a;
    room    = DEPTH - base;
    exp_cnt = (n < room) ? n : room;
    exp_err = (n > room);
    start     = 1'b1;
    base_addr = ADDR_W'(base);
    tick();
    start     = 1'b0;
    base_addr = ADDR_W'($urandom());
    chk("load_entry_ready", 64'(in_ready), 64'd1);
    chk("load_entry_count", 64'(count), 64'd0);
    chk("load_entry_err", 64'(err), 64'd0);
    for (int i = 0; i < n; i++) begin
      int gaps;
      gaps = $urandom_range(0, maxgap);
      for (int g = 0; g < gaps; g++) begin
        in_valid = 1'b0;
        in_last  = 1'($urandom_range(0, 1));
        rand_fields();
        tick();
      end
      rand_fields();
      if (directed) begin
        in_op = 5'h02; in_mode = 2'd1; in_src = 5'd3; in_dst = 5'd4; in_lit = 32'hDEADBEEF;
      end
      in_valid = 1'b1;
      in_last  = (i == n - 1);
      if (spurious_start && i == 1) begin
        start     = 1'b1;
        base_addr = ADDR_W'(base + 100);
      end
      w = directed ? 49'h0_2464_DEADBEEF : {in_op, in_mode, in_src, in_dst, in_lit};
      a = ADDR_W'(base + i);
      if (i < room) exp_q.push_back({a, w});
      if (!in_ready) begin
        errors++;
        checks++;
        $display("FAIL beat_ready got=0 expected=1 (beat %0d)", i);
      end
      tick();
      start = 1'b0;
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    done_exp++;
    chk("done_pulse", 64'(done), 64'd1);
    chk("done_busy", 64'(busy), 64'd1);
    chk("done_count", 64'(count), 64'(exp_cnt));
    chk("done_err", 64'(err), 64'(exp_err));
    tick();
    chk("idle_done", 64'(done), 64'd0);
    chk("idle_busy", 64'(busy), 64'd0);
    chk("idle_ready", 64'(in_ready), 64'd0);
    chk("idle_count_hold", 64'(count), 64'(exp_cnt));
    chk("idle_err_hold", 64'(err), 64'(exp_err));
    chk("queue_drained", 64'(exp_q.size()), 64'd0);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_ready"}, 64'(in_ready), 64'd0);
    chk({tag, "_we"}, 64'(imem_we), 64'd0);
    chk({tag, "_addr"}, 64'(imem_addr), 64'd0);
    chk({tag, "_wdata"}, 64'(imem_wdata), 64'd0);
    chk({tag, "_busy"}, 64'(busy), 64'd0);
    chk({tag, "_done"}, 64'(done), 64'd0);
    chk({tag, "_count"}, 64'(count), 64'd0);
    chk({tag, "_err"}, 64'(err), 64'd0);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; base_addr = '0; in_valid = 1'b0; in_last = 1'b0;
    in_op = '0; in_mode = '0; in_src = '0; in_dst = '0; in_lit = '0;
    tick();
    tick();
    rst = 1'b0;
    chk_zero("reset");

    // Single directed beat: canonical encoding at base 0x10.
    session(16'h10, 1, 0, 1'b0, 1'b1);

    // Back-to-back burst of four from address 0.
    session(0, 4, 0, 1'b0, 1'b0);

    // Gapped beats with in_valid toggling between accepted beats.
    session(8'h30, 5, 2, 1'b0, 1'b0);

    // in_valid held high in IDLE must not consume a beat.
    in_valid = 1'b1;
    rand_fields();
    tick();
    tick();
    chk("idle_valid_ready", 64'(in_ready), 64'd0);
    in_valid = 1'b0;
    tick();

    // start pulsed during LOAD must not move the write pointer.
    session(8'h50, 4, 1, 1'b1, 1'b0);

    // Top of memory: three writes then two dropped beats; next session clears.
    session(DEPTH - 3, 5, 1, 1'b0, 1'b0);
    session(8'h10, 3, 0, 1'b0, 1'b0);

    // Full memory exactly, then overfull.
    session(0, DEPTH, 0, 1'b0, 1'b0);
    session(0, DEPTH + 2, 0, 1'b0, 1'b0);

    // Reset one cycle after the 2nd of 5 beats: beat 3 is offered in the reset cycle.
    begin
      int done_before;
      start = 1'b1;
      base_addr = 8'h40;
      tick();
      start = 1'b0;
      for (int i = 0; i < 2; i++) begin
        rand_fields();
        in_valid = 1'b1;
        exp_q.push_back({ADDR_W'(8'h40 + i), {in_op, in_mode, in_src, in_dst, in_lit}});
        tick();
      end
      rand_fields();
      done_before = done_seen;
      rst = 1'b1;
      tick();
      rst = 1'b0;
      in_valid = 1'b0;
      chk_zero("midreset");
      tick();
      tick();
      chk("midreset_no_done", 64'(done_seen), 64'(done_before));
      chk("midreset_queue", 64'(exp_q.size()), 64'd0);
    end
    session(8'h20, 5, 1, 1'b0, 1'b0);

    // A few fully random sessions.
    for (int s = 0; s < 6; s++) begin
      session($urandom_range(0, DEPTH - 1), $urandom_range(1, 12), 2, 1'($urandom_range(0, 1)), 1'b0);
    end

    tick();
    chk("done_total", 64'(done_seen), 64'(done_exp));
    chk("final_queue", 64'(exp_q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Watchdog so the run always terminates.
  initial begin
    #500000;
    $display("FAIL watchdog timeout reached");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/instr_mem_loader.md
# instr_mem_loader

Encoder and writer for the 49-bit instruction word consumed by the instruction decoder. Accepts decoded-field beats (op, mode, src, dst, literal) over a valid/ready stream, packs each beat into the canonical instruction format, and writes the words sequentially into instruction memory starting at a programmed base address. It sits between the program source (testbench, boot loader, host port) and the instruction memory write port. It reports busy, completion, word count and overflow.

## Interface
- ADDR_W, 8, instruction memory address width; highest address LAST_ADDR = 2^ADDR_W-1
- clk  in  1  clock; all state changes on rising edge
- rst  in  1  synchronous reset, active-high
- start  in  1  begin a load session; sampled only in IDLE
- base_addr  in  ADDR_W  first write address, captured when start is accepted
- in_valid  in  1  field beat valid
- in_ready  out  1  block accepts a beat this cycle
- in_op  in  5  opcode
- in_mode  in  2  addressing mode
- in_src  in  5  source register
- in_dst  in  5  destination register
- in_lit  in  32  literal/source value
- in_last  in  1  beat is the final instruction of the session
- imem_we  out  1  instruction memory write enable
- imem_addr  out  ADDR_W  write address
- imem_wdata  out  49  encoded instruction
- busy  out  1  high in LOAD and DONE
- done  out  1  one-cycle completion pulse
- count  out  ADDR_W+1  words written this session
- err  out  1  sticky overflow flag

## Operation
- Encoding: imem_wdata = {in_op, in_mode, in_src, in_dst, in_lit}. Bits [48:44] hold op, [43:42] mode, [41:37] src, [36:32] dst, [31:0] literal. Field values are not checked; all values are legal.
- Beat accepted when in_valid & in_ready. in_ready = (state == LOAD).
- States:
  - IDLE: in_ready=0. start -> LOAD. Capture wr_ptr=base_addr; clear count, err and the wrapped flag.
  - LOAD: each accepted beat is written unless wrapped is set. An accepted beat with in_last -> DONE.
  - DONE: lasts one cycle, then goes to IDLE unconditionally.
- start outside IDLE is ignored. in_valid in IDLE is ignored and no beat is consumed.
- Pointer: after each performed write, wr_ptr increments modulo 2^ADDR_W. A write at LAST_ADDR sets wrapped.
- Overflow: a beat accepted while wrapped=1 is consumed but dropped. No imem_we, count does not change, and err is set. in_last on a dropped beat still ends the session. err holds until the next accepted start or rst.
- count saturates naturally at 2^ADDR_W (full memory), which is why it is ADDR_W+1 bits wide.
- rst: state=IDLE; in_ready, imem_we, imem_addr, imem_wdata, busy, done, count and err all read 0 in the cycle after the reset edge. A write still in flight is discarded. Reset mid-session abandons the session with no done pulse.

## Timing
- Write port is registered. A beat accepted in cycle N gives imem_we=1 with imem_addr and imem_wdata valid in cycle N+1, for exactly one cycle. In cycles without a write, imem_wdata and imem_addr hold their last values.
- Throughput is one beat per cycle in LOAD, with no bubbles between beats.
- start accepted in cycle S puts the block in LOAD in cycle S+1 (in_ready=1 first in S+1). busy is high from S+1.
- Last beat accepted in cycle N gives DONE in N+1: done=1, and the final imem_we also falls in N+1. The block returns to IDLE in N+2, with busy=0 and in_ready=0.
- count and err update in the same cycle as the corresponding imem_we or drop decision, and are visible from N+1.
- A new start is possible in cycle N+2 at the earliest.

## Test plan
- Encode check: base 0x10, a single beat op=0x02, mode=1, src=3, dst=4, lit=0xDEADBEEF, last=1 -> one write, addr 0x10, wdata 49'h0_2464_DEADBEEF. done pulses in the write cycle, count=1, err=0.
- Burst: base 0x00, 4 back-to-back beats with last on the 4th -> writes on 4 consecutive cycles at addr 0..3 in order, count=4, one done pulse, in_ready low the cycle after DONE.
- Backpressure and gaps: in_valid toggled 1,0,0,1,1 -> writes only one cycle after each accepted beat, addresses contiguous, no duplicate or skipped writes.
- Wrap/overflow (ADDR_W=2): base 3, 3 beats -> write at addr 3 only. The 2nd and 3rd beats are dropped, err=1, count=1, and done still pulses. A following start clears err and count.
- Reset mid-session: rst asserted one cycle after the 2nd of 5 beats -> no further imem_we, no done pulse, all outputs 0. The next start with base 0x20 writes correctly from 0x20.
- Ignored controls: start pulsed during LOAD, and in_valid held high while IDLE -> no base-address change in LOAD and no beat consumed in IDLE.
